// File: rtl/robertson_seq_if.sv
// Signal bundle between the Robertson operand/result sequencer and its surroundings:
// upstream operand handshake, multiplier bus and downstream product handshake.
interface robertson_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_m;
  logic [7:0]  in_q;
  logic        mul_enable;
  logic [7:0]  mul_inbus;
  logic        mul_done;
  logic [7:0]  mul_outbus;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic        out_error;
  logic        busy;

  modport slave (
    input  in_valid, in_m, in_q, mul_done, mul_outbus, out_ready,
    output in_ready, mul_enable, mul_inbus, out_valid, out_product, out_error, busy
  );

  modport master (
    output in_valid, in_m, in_q, mul_done, mul_outbus, out_ready,
    input  in_ready, mul_enable, mul_inbus, out_valid, out_product, out_error, busy
  );
endinterface

// File: rtl/robertson_seq.sv
// Sequencer around the 8-bit Robertson multiplier: serialises M then Q onto the
// shared bus, waits for done (with timeout), collects {A,Q} and hands it downstream.
module robertson_seq #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  robertson_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_WAIT   = 3'd3,
    S_CAP_LO = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [7:0]  q_r;
  logic [7:0]  cnt_r;
  logic        in_ready_r;
  logic        mul_enable_r;
  logic [7:0]  mul_inbus_r;
  logic        out_valid_r;
  logic [15:0] product_r;
  logic        error_r;
  logic        busy_r;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      q_r          <= 8'd0;
      cnt_r        <= 8'd0;
      in_ready_r   <= 1'b1;
      mul_enable_r <= 1'b0;
      mul_inbus_r  <= 8'd0;
      out_valid_r  <= 1'b0;
      product_r    <= 16'd0;
      error_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // M goes straight onto the bus register so it is visible during LOAD_M.
          if (bus.in_valid && in_ready_r) begin
            q_r          <= bus.in_q;
            mul_inbus_r  <= bus.in_m;
            mul_enable_r <= 1'b1;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= S_LOAD_M;
          end
        end
        S_LOAD_M: begin
          mul_enable_r <= 1'b0;
          mul_inbus_r  <= q_r;
          state_r      <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          mul_inbus_r <= 8'd0;
          cnt_r       <= 8'd0;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            product_r[15:8] <= bus.mul_outbus;
            state_r         <= S_CAP_LO;
          end else if (cnt_r == CNT_LAST) begin
            error_r     <= 1'b1;
            product_r   <= 16'd0;
            out_valid_r <= 1'b1;
            state_r     <= S_OUT;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_CAP_LO: begin
          product_r[7:0] <= bus.mul_outbus;
          error_r        <= 1'b0;
          out_valid_r    <= 1'b1;
          state_r        <= S_OUT;
        end
        S_OUT: begin
          // Product and error are left untouched on exit; only valid drops.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          in_ready_r   <= 1'b1;
          mul_enable_r <= 1'b0;
          mul_inbus_r  <= 8'd0;
          out_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.mul_enable  = mul_enable_r;
  assign bus.mul_inbus   = mul_inbus_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_product = product_r;
  assign bus.out_error   = error_r;
  assign bus.busy        = busy_r;

endmodule
